i2c_target_mem: RTL and testbench

- I2C target (slave) that sits directly downstream of the group's I2C master on the SCL/SDA bus.
- Consumes the master's START / address / write-data / read sequences.
- ACKs its own 7-bit address, stores written bytes into a 16-byte register file and returns stored bytes on reads.
- Gives the master bench a real responding device so ACK and read-data paths are exercised end-to-end.

---
 rtl/i2c_target_mem.sv | 258 +++++++++++++++++++++++++
 tb/tb_i2c_target_mem.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_mem.sv
`default_nettype none
// ============================================================================
// i2c_target_mem : I2C target that ACKs DEV_ADDR and serves a small byte RAM
// Revision       : 1.0
// ============================================================================
module i2c_target_mem #(
   parameter logic [6:0] DEV_ADDR   = 7'h50,
   parameter int         DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  scl,
   input  logic                  sda_in,
   output logic                  sda_oe,
   output logic                  wr_strobe,
   output logic [DEPTH_LOG2-1:0] wr_idx,
   output logic [7:0]            wr_byte,
   input  logic [DEPTH_LOG2-1:0] host_idx,
   output logic [7:0]            host_rdata,
   output logic                  busy,
   output logic                  start_det,
   output logic                  stop_det
);

   localparam int                    c_depth   = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2-1:0] c_ptr_one = DEPTH_LOG2'(1);

   localparam logic [2:0] c_st_idle      = 3'd0;
   localparam logic [2:0] c_st_addr      = 3'd1;
   localparam logic [2:0] c_st_addr_ack  = 3'd2;
   localparam logic [2:0] c_st_write     = 3'd3;
   localparam logic [2:0] c_st_write_ack = 3'd4;
   localparam logic [2:0] c_st_read      = 3'd5;
   localparam logic [2:0] c_st_read_ack  = 3'd6;
   localparam logic [2:0] c_st_ignore    = 3'd7;

   logic                  r_scl_s1, r_scl_s2, r_scl_d;
   logic                  r_sda_s1, r_sda_s2, r_sda_d;
   logic                  w_scl_rise, w_scl_fall, w_start, w_stop;

   logic [2:0]            r_state, w_state_next;
   logic [3:0]            r_cnt, w_cnt_next;
   logic [7:0]            r_shift, w_shift_next;
   logic                  r_sda_oe, w_sda_oe_next;
   logic                  r_busy, w_busy_next;
   logic                  r_rw, w_rw_next;
   logic [DEPTH_LOG2-1:0] r_ptr, w_ptr_next;
   logic                  w_commit;
   logic [7:0]            w_mem_rd;

   logic                  r_wr_strobe;
   logic [DEPTH_LOG2-1:0] r_wr_idx;
   logic [7:0]            r_wr_byte;
   logic                  r_start_det, r_stop_det;
   logic [7:0]            r_mem [0:c_depth-1];

   // Sync flops reset to the idle bus level so reset release creates no edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_scl_s1 <= 1'b1;
         r_scl_s2 <= 1'b1;
         r_scl_d  <= 1'b1;
         r_sda_s1 <= 1'b1;
         r_sda_s2 <= 1'b1;
         r_sda_d  <= 1'b1;
      end else begin
         r_scl_s1 <= scl;
         r_scl_s2 <= r_scl_s1;
         r_scl_d  <= r_scl_s2;
         r_sda_s1 <= sda_in;
         r_sda_s2 <= r_sda_s1;
         r_sda_d  <= r_sda_s2;
      end
   end

   assign w_scl_rise = r_scl_s2 & ~r_scl_d;
   assign w_scl_fall = ~r_scl_s2 & r_scl_d;
   assign w_start    = r_scl_s2 & r_scl_d & ~r_sda_s2 & r_sda_d;
   assign w_stop     = r_scl_s2 & r_scl_d & r_sda_s2 & ~r_sda_d;
   assign w_mem_rd   = r_mem[r_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= c_st_idle;
      else      r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (w_start) begin
         w_state_next = c_st_addr;
      end else if (w_stop) begin
         w_state_next = c_st_idle;
      end else begin
         case (r_state)
            c_st_addr: begin
               if (w_scl_rise && r_cnt == 4'd7 && r_shift[6:0] != DEV_ADDR)
                  w_state_next = c_st_ignore;
               else if (w_scl_fall && r_cnt == 4'd8)
                  w_state_next = c_st_addr_ack;
            end
            c_st_addr_ack:  if (w_scl_fall) w_state_next = r_rw ? c_st_read : c_st_write;
            c_st_write:     if (w_scl_fall && r_cnt == 4'd8) w_state_next = c_st_write_ack;
            c_st_write_ack: if (w_scl_fall) w_state_next = c_st_write;
            c_st_read:      if (w_scl_fall && r_cnt == 4'd8) w_state_next = c_st_read_ack;
            c_st_read_ack: begin
               if (w_scl_rise && r_sda_s2)
                  w_state_next = c_st_ignore;
               else if (w_scl_fall && r_cnt == 4'd1)
                  w_state_next = c_st_read;
            end
            default: w_state_next = r_state;
         endcase
      end
   end

   // Datapath next values; every SDA drive change is qualified by an SCL fall.
   always_comb begin
      w_cnt_next    = r_cnt;
      w_shift_next  = r_shift;
      w_sda_oe_next = r_sda_oe;
      w_busy_next   = r_busy;
      w_rw_next     = r_rw;
      w_ptr_next    = r_ptr;
      w_commit      = 1'b0;
      if (w_start) begin
         w_cnt_next    = 4'd0;
         w_sda_oe_next = 1'b0;
      end else if (w_stop) begin
         w_busy_next   = 1'b0;
         w_sda_oe_next = 1'b0;
      end else begin
         case (r_state)
            c_st_addr: begin
               if (w_scl_rise && r_cnt != 4'd8) begin
                  w_shift_next = {r_shift[6:0], r_sda_s2};
                  w_cnt_next   = r_cnt + 4'd1;
                  if (r_cnt == 4'd7) begin
                     if (r_shift[6:0] == DEV_ADDR) begin
                        w_busy_next = 1'b1;
                        w_rw_next   = r_sda_s2;
                     end else begin
                        w_busy_next = 1'b0;
                     end
                  end
               end else if (w_scl_fall && r_cnt == 4'd8) begin
                  w_sda_oe_next = 1'b1;
               end
            end
            c_st_addr_ack: begin
               if (w_scl_fall) begin
                  w_cnt_next = 4'd0;
                  if (r_rw) begin
                     w_shift_next  = w_mem_rd;
                     w_ptr_next    = r_ptr + c_ptr_one;
                     w_sda_oe_next = ~w_mem_rd[7];
                  end else begin
                     w_sda_oe_next = 1'b0;
                  end
               end
            end
            c_st_write: begin
               if (w_scl_rise && r_cnt != 4'd8) begin
                  w_shift_next = {r_shift[6:0], r_sda_s2};
                  w_cnt_next   = r_cnt + 4'd1;
               end else if (w_scl_fall && r_cnt == 4'd8) begin
                  w_sda_oe_next = 1'b1;
                  w_commit      = 1'b1;
                  w_ptr_next    = r_ptr + c_ptr_one;
               end
            end
            c_st_write_ack: begin
               if (w_scl_fall) begin
                  w_sda_oe_next = 1'b0;
                  w_cnt_next    = 4'd0;
               end
            end
            c_st_read: begin
               if (w_scl_rise && r_cnt != 4'd8) begin
                  w_cnt_next = r_cnt + 4'd1;
               end else if (w_scl_fall && r_cnt == 4'd8) begin
                  w_sda_oe_next = 1'b0;
                  w_cnt_next    = 4'd0;
               end else if (w_scl_fall && r_cnt != 4'd0) begin
                  w_shift_next  = {r_shift[6:0], 1'b0};
                  w_sda_oe_next = ~r_shift[6];
               end
            end
            c_st_read_ack: begin
               // r_cnt==1 marks a sampled master ACK awaiting the next SCL fall.
               if (w_scl_rise) begin
                  if (r_sda_s2) w_busy_next = 1'b0;
                  else          w_cnt_next  = 4'd1;
               end else if (w_scl_fall && r_cnt == 4'd1) begin
                  w_cnt_next    = 4'd0;
                  w_shift_next  = w_mem_rd;
                  w_ptr_next    = r_ptr + c_ptr_one;
                  w_sda_oe_next = ~w_mem_rd[7];
               end
            end
            c_st_ignore: begin
               w_sda_oe_next = 1'b0;
               w_busy_next   = 1'b0;
            end
            default: w_sda_oe_next = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt       <= 4'd0;
         r_shift     <= 8'd0;
         r_sda_oe    <= 1'b0;
         r_busy      <= 1'b0;
         r_rw        <= 1'b0;
         r_ptr       <= '0;
         r_wr_strobe <= 1'b0;
         r_wr_idx    <= '0;
         r_wr_byte   <= 8'd0;
         r_start_det <= 1'b0;
         r_stop_det  <= 1'b0;
      end else begin
         r_cnt       <= w_cnt_next;
         r_shift     <= w_shift_next;
         r_sda_oe    <= w_sda_oe_next;
         r_busy      <= w_busy_next;
         r_rw        <= w_rw_next;
         r_ptr       <= w_ptr_next;
         r_wr_strobe <= w_commit;
         r_start_det <= w_start;
         r_stop_det  <= w_stop;
         if (w_commit) begin
            r_wr_idx  <= r_ptr;
            r_wr_byte <= r_shift;
         end
      end
   end

   // RAM updates at the end of the strobe cycle so a same-cycle host read sees old data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < c_depth; i++) r_mem[i] <= 8'd0;
      end else if (r_wr_strobe) begin
         r_mem[r_wr_idx] <= r_wr_byte;
      end
   end

   assign host_rdata = r_mem[host_idx];
   assign sda_oe     = r_sda_oe;
   assign wr_strobe  = r_wr_strobe;
   assign wr_idx     = r_wr_idx;
   assign wr_byte    = r_wr_byte;
   assign busy       = r_busy;
   assign start_det  = r_start_det;
   assign stop_det   = r_stop_det;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_mem.sv
`default_nettype none
// ============================================================================
// tb_i2c_target_mem : directed bit-banged I2C master against i2c_target_mem
// Revision          : 1.0
// ============================================================================
module tb_i2c_target_mem;

   localparam int c_q = 10;

   logic       clk = 1'b0;
   logic       rst;
   logic       scl;
   logic       sda_m;
   logic       sda_line;
   logic       sda_oe;
   logic       wr_strobe;
   logic [3:0] wr_idx;
   logic [7:0] wr_byte;
   logic [3:0] host_idx;
   logic [7:0] host_rdata;
   logic       busy;
   logic       start_det;
   logic       stop_det;

   always #5 clk = ~clk;
   assign sda_line = sda_m & ~sda_oe;

   i2c_target_mem #(.DEV_ADDR(7'h50), .DEPTH_LOG2(4)) u_dut (
      .clk(clk), .rst(rst), .scl(scl), .sda_in(sda_line), .sda_oe(sda_oe),
      .wr_strobe(wr_strobe), .wr_idx(wr_idx), .wr_byte(wr_byte),
      .host_idx(host_idx), .host_rdata(host_rdata), .busy(busy),
      .start_det(start_det), .stop_det(stop_det)
   );

   int checks = 0;
   int errors = 0;
   int wr_cnt = 0, start_cnt = 0, stop_cnt = 0, oe_cnt = 0, busy_cnt = 0;
   logic [3:0] log_idx  [0:63];
   logic [7:0] log_byte [0:63];
   logic [7:0] old_rd = 8'hFF;

   always @(negedge clk) begin
      if (wr_strobe) begin
         if (wr_cnt < 64) begin
            log_idx[wr_cnt]  <= wr_idx;
            log_byte[wr_cnt] <= wr_byte;
         end
         if (wr_idx == host_idx) old_rd <= host_rdata;
         wr_cnt <= wr_cnt + 1;
      end
      if (start_det) start_cnt <= start_cnt + 1;
      if (stop_det)  stop_cnt  <= stop_cnt + 1;
      if (sda_oe)    oe_cnt    <= oe_cnt + 1;
      if (busy)      busy_cnt  <= busy_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic hq();
      repeat (c_q) @(negedge clk);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; hq(); scl = 1'b1; hq(); sda_m = 1'b0; hq(); scl = 1'b0; hq();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; hq(); scl = 1'b1; hq(); sda_m = 1'b1; hq();
   endtask

   task automatic wb(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) begin
         sda_m = b[i]; hq(); scl = 1'b1; hq(); hq(); scl = 1'b0; hq();
      end
      sda_m = 1'b1; hq(); scl = 1'b1; hq(); ack = sda_line; hq(); scl = 1'b0; hq();
   endtask

   task automatic rb(input logic mack, output logic [7:0] b, output logic oe_ack);
      sda_m = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         hq(); scl = 1'b1; hq(); b[i] = sda_line; hq(); scl = 1'b0;
      end
      sda_m = ~mack; hq(); scl = 1'b1; hq(); oe_ack = sda_oe; hq(); scl = 1'b0; hq();
      sda_m = 1'b1;
   endtask

   initial begin
      logic       ack;
      logic       oe_ack;
      logic [7:0] rd;
      int         base, sc, oc, bc, nacks;

      rst = 1'b0; scl = 1'b1; sda_m = 1'b1; host_idx = 4'd0;
      repeat (5) @(negedge clk);
      chk("rst_sda_oe", sda_oe, 0);
      chk("rst_busy", busy, 0);
      chk("rst_wr_strobe", wr_strobe, 0);
      chk("rst_wr_idx", wr_idx, 0);
      chk("rst_wr_byte", wr_byte, 0);
      chk("rst_start_det", start_det, 0);
      chk("rst_stop_det", stop_det, 0);
      chk("rst_host_rdata", host_rdata, 0);
      rst = 1'b1;
      repeat (5) @(negedge clk);

      // single write
      base = wr_cnt; sc = stop_cnt;
      i2c_start();
      wb(8'hA0, ack); chk("wr_addr_ack", ack, 0); chk("wr_busy", busy, 1);
      wb(8'hA5, ack); chk("wr_data_ack", ack, 0);
      i2c_stop(); repeat (5) @(negedge clk);
      chk("wr_count", wr_cnt - base, 1);
      chk("wr_idx", log_idx[base], 0);
      chk("wr_byte", log_byte[base], 8'hA5);
      host_idx = 4'd0; #1;
      chk("wr_rdata0", host_rdata, 8'hA5);
      chk("wr_busy_after_stop", busy, 0);
      chk("wr_stop_det", stop_cnt - sc, 1);

      // address mismatch
      base = wr_cnt; sc = stop_cnt; oc = oe_cnt; bc = busy_cnt;
      i2c_start();
      wb(8'hA2, ack); chk("mm_addr_nack", ack, 1);
      wb(8'h3C, ack); chk("mm_data_nack", ack, 1);
      i2c_stop(); repeat (5) @(negedge clk);
      chk("mm_oe_never", oe_cnt - oc, 0);
      chk("mm_no_write", wr_cnt - base, 0);
      chk("mm_busy_never", busy_cnt - bc, 0);
      chk("mm_stop_det", stop_cnt - sc, 1);

      // reset clears RAM and pointer
      @(negedge clk); rst = 1'b0; repeat (2) @(negedge clk);
      chk("rst2_rdata0", host_rdata, 0);
      rst = 1'b1; repeat (5) @(negedge clk);

      // wrap: 17 writes 0x00..0x10 from idx 0
      base = wr_cnt; nacks = 0;
      i2c_start();
      wb(8'hA0, ack); nacks += int'(ack);
      for (int i = 0; i < 17; i++) begin
         wb(8'(i), ack); nacks += int'(ack);
      end
      i2c_stop(); repeat (5) @(negedge clk);
      chk("wrap_acks", nacks, 0);
      chk("wrap_count", wr_cnt - base, 17);
      for (int i = 0; i < 17; i++) begin
         chk($sformatf("wrap_idx%0d", i), log_idx[base + i], i % 16);
         chk($sformatf("wrap_byte%0d", i), log_byte[base + i], i);
      end
      chk("wrap_old_rd", old_rd, 8'h00);
      host_idx = 4'd0;  #1; chk("wrap_mem0", host_rdata, 8'h10);
      host_idx = 4'd15; #1; chk("wrap_mem15", host_rdata, 8'h0F);

      // fill 16 bytes from ptr 1 (0x11, 0x22, then 0x40|idx), ptr returns to 1
      i2c_start();
      wb(8'hA0, ack);
      for (int j = 0; j < 16; j++) begin
         if (j == 0)      wb(8'h11, ack);
         else if (j == 1) wb(8'h22, ack);
         else             wb(8'h40 | 8'((1 + j) % 16), ack);
      end
      i2c_stop(); repeat (5) @(negedge clk);
      host_idx = 4'd0; #1; chk("fill_mem0", host_rdata, 8'h40);

      // read back two bytes
      i2c_start();
      wb(8'hA1, ack); chk("rd_addr_ack", ack, 0);
      rb(1'b1, rd, oe_ack); chk("rd_byte0", rd, 8'h11); chk("rd_oe_mack0", oe_ack, 0);
      rb(1'b0, rd, oe_ack); chk("rd_byte1", rd, 8'h22); chk("rd_oe_mack1", oe_ack, 0);
      chk("rd_busy_after_nack", busy, 0);
      i2c_stop(); repeat (5) @(negedge clk);

      // repeated START: write 0x77 at idx 3, then read mem[4]
      sc = start_cnt; base = wr_cnt;
      i2c_start();
      wb(8'hA0, ack);
      wb(8'h77, ack);
      i2c_start();
      wb(8'hA1, ack); chk("rs_addr_ack", ack, 0);
      rb(1'b0, rd, oe_ack); chk("rs_rd", rd, 8'h44);
      i2c_stop(); repeat (5) @(negedge clk);
      chk("rs_start_det", start_cnt - sc, 2);
      chk("rs_wr_idx", log_idx[base], 3);

      // reset while target drives SDA (mem[5]=0x45 has MSB 0)
      i2c_start();
      wb(8'hA1, ack);
      chk("mr_oe_driving", sda_oe, 1);
      rst = 1'b0; #1;
      chk("mr_oe_released", sda_oe, 0);
      repeat (3) @(negedge clk); rst = 1'b1; repeat (3) @(negedge clk);
      i2c_stop(); repeat (5) @(negedge clk);
      base = wr_cnt;
      i2c_start();
      wb(8'hA0, ack); chk("mr_addr_ack", ack, 0);
      wb(8'h5A, ack); chk("mr_data_ack", ack, 0);
      i2c_stop(); repeat (5) @(negedge clk);
      chk("mr_wr_count", wr_cnt - base, 1);
      chk("mr_wr_idx", log_idx[base], 0);
      chk("mr_wr_byte", log_byte[base], 8'h5A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
